// File: rtl/ofs_fim_pcie_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ofs_fim_pcie_pkg
//  Description : Shared types and constants for the MSI-X interrupt scheduler.
//                Shadow-table entry layout, VF number width, init FSM
//                encoding and an index-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ofs_fim_pcie_pkg;

    localparam int MSIX_VF_NUM_W = 11;

    // Per-function shadow of the EP's MSI-X related config bits
    typedef struct packed {
        logic en;
        logic mask;
        logic bme;
    } t_msix_shdw_entry;

    // Shadow init FSM encoding
    localparam logic [0:0] SHDW_INIT = 1'b0;
    localparam logic [0:0] SHDW_RUN  = 1'b1;

    // Index width for an n-entry table, never below one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Map the low cfg bits {en, mask, bme} of a shadow record to an entry
    function automatic t_msix_shdw_entry cfg_to_entry(input logic [2:0] cfg);
        t_msix_shdw_entry e;
        e.en   = cfg[2];
        e.mask = cfg[1];
        e.bme  = cfg[0];
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pcie_msix_irq_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : pcie_msix_irq_sched_if
//  Description : Shadow-record input, interrupt request and grant handshake
//                bundle of the MSI-X interrupt scheduler. The slave modport
//                is the scheduler's view, master is the surrounding logic.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pcie_msix_irq_sched_if #(
    parameter int NUM_VF = 4
);
    import ofs_fim_pcie_pkg::*;

    logic                     ctl_shdw_update;
    logic [1:0]               ctl_shdw_pf_num;
    logic [MSIX_VF_NUM_W-1:0] ctl_shdw_vf_num;
    logic                     ctl_shdw_vf_active;
    logic [6:0]               ctl_shdw_cfg;
    logic                     ctl_shdw_req_all;
    logic                     shdw_rescan;
    logic [NUM_VF:0]          irq_req;
    logic                     irq_valid;
    logic                     irq_ready;
    logic                     irq_vf_active;
    logic [MSIX_VF_NUM_W-1:0] irq_vf_num;
    logic [NUM_VF:0]          irq_pending;

    modport slave (
        input  ctl_shdw_update, ctl_shdw_pf_num, ctl_shdw_vf_num,
               ctl_shdw_vf_active, ctl_shdw_cfg, shdw_rescan, irq_req,
               irq_ready,
        output ctl_shdw_req_all, irq_valid, irq_vf_active, irq_vf_num,
               irq_pending
    );

    modport master (
        output ctl_shdw_update, ctl_shdw_pf_num, ctl_shdw_vf_num,
               ctl_shdw_vf_active, ctl_shdw_cfg, shdw_rescan, irq_req,
               irq_ready,
        input  ctl_shdw_req_all, irq_valid, irq_vf_active, irq_vf_num,
               irq_pending
    );

endinterface
`default_nettype wire

// File: rtl/pcie_msix_irq_sched_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : msix_rr_arb
//  Description : Round-robin arbiter. Search starts at the index following
//                the last granted one; grant is combinational one-hot, the
//                pointer moves only when the caller accepts it (advance).
//  Revision    : 1.0 - initial release
// ============================================================================
module msix_rr_arb
    import ofs_fim_pcie_pkg::*;
#(
    parameter int N = 5
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic [N-1:0] req,
    input  wire logic         advance,
    output logic      [N-1:0] gnt
);
    localparam int IDX_W = idx_w(N);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gidx;
    logic [IDX_W:0]   cand;
    logic             found;

    // First requester at or after the pointer, wrapping at N
    always_comb begin
        gnt   = '0;
        gidx  = '0;
        found = 1'b0;
        cand  = '0;
        for (int off = 0; off < N; off++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(off);
            if (cand >= (IDX_W+1)'(N)) begin
                cand = cand - (IDX_W+1)'(N);
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found                 = 1'b1;
                gnt[cand[IDX_W-1:0]]  = 1'b1;
                gidx                  = cand[IDX_W-1:0];
            end
        end
    end

    // Pointer moves to the slot after an accepted grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (gidx == IDX_W'(N-1)) ? '0 : gidx + IDX_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pcie_msix_irq_sched.sv
`default_nettype none
// ============================================================================
//  Module      : pcie_msix_irq_sched
//  Description : MSI-X interrupt scheduler for PF0 and its VFs. Keeps a
//                shadow of {en, mask, bme} per function fed by EP shadow
//                records, coalesces interrupt requests into pending bits and
//                grants eligible functions round-robin over a valid/ready
//                handshake. Build macro MSIX_SHDW_BME_GATE_EN additionally
//                gates eligibility on bus master enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module pcie_msix_irq_sched
    import ofs_fim_pcie_pkg::*;
#(
    parameter int NUM_VF      = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  wire logic           fim_clk,
    input  wire logic           fim_rst_n,
    pcie_msix_irq_sched_if.slave bus
);
    localparam int NUM_ENT = NUM_VF + 1;
    localparam int IDX_W   = idx_w(NUM_ENT);
    localparam int CNT_W   = idx_w(TIMEOUT_CYC);

    // Init FSM and dump-request timeout
    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_drop;
    logic             req_all;
    logic             grant_en;

    // Shadow table
    t_msix_shdw_entry shdw_tbl [NUM_ENT];
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [NUM_ENT-1:0] en_vec;
    logic [NUM_ENT-1:0] mask_vec;
    logic [NUM_ENT-1:0] bme_vec;
    logic [NUM_ENT-1:0] dis_clr;

    // Pending / arbitration / grant
    logic [NUM_ENT-1:0] pending;
    logic [NUM_ENT-1:0] elig;
    logic [NUM_ENT-1:0] arb_req;
    logic [NUM_ENT-1:0] arb_gnt;
    logic [NUM_ENT-1:0] grant_oh;
    logic [NUM_ENT-1:0] hs_clr;
    logic [IDX_W-1:0]   gnt_idx;
    logic               hs;
    logic               load;
    logic               valid;
    logic               vf_active;
    logic [MSIX_VF_NUM_W-1:0] vf_num;

    logic unused_cfg_hi;
    assign unused_cfg_hi = ^bus.ctl_shdw_cfg[6:3];

    // Only PF0 records for the PF itself or an existing VF update the table
    assign wr_en  = bus.ctl_shdw_update && (bus.ctl_shdw_pf_num == 2'd0) &&
                    (!bus.ctl_shdw_vf_active ||
                     (bus.ctl_shdw_vf_num < MSIX_VF_NUM_W'(NUM_VF)));
    assign wr_idx = bus.ctl_shdw_vf_active ?
                    IDX_W'(bus.ctl_shdw_vf_num) + IDX_W'(1) : '0;

    // Init FSM state register
    always_ff @(posedge fim_clk or negedge fim_rst_n) begin
        if (!fim_rst_n) begin
            state <= SHDW_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Init FSM next state: any record ends the dump wait, rescan restarts it
    always_comb begin
        state_nxt = state;
        case (state)
            SHDW_INIT: if (bus.ctl_shdw_update) state_nxt = SHDW_RUN;
            SHDW_RUN:  if (bus.shdw_rescan)     state_nxt = SHDW_INIT;
            default:   state_nxt = SHDW_INIT;
        endcase
    end

    // Init FSM outputs: dump request (with one-cycle timeout gap), grant gate
    always_comb begin
        req_all  = (state == SHDW_INIT) && !tmo_drop;
        grant_en = (state == SHDW_RUN);
    end

    // Timeout counter: after TIMEOUT_CYC quiet cycles drop req_all once
    always_ff @(posedge fim_clk or negedge fim_rst_n) begin
        if (!fim_rst_n) begin
            tmo_cnt  <= '0;
            tmo_drop <= 1'b0;
        end else if ((state != SHDW_INIT) || bus.ctl_shdw_update || tmo_drop) begin
            tmo_cnt  <= '0;
            tmo_drop <= 1'b0;
        end else if (tmo_cnt == CNT_W'(TIMEOUT_CYC-1)) begin
            tmo_cnt  <= '0;
            tmo_drop <= 1'b1;
        end else begin
            tmo_cnt  <= tmo_cnt + CNT_W'(1);
        end
    end

    // Shadow table write
    always_ff @(posedge fim_clk or negedge fim_rst_n) begin
        if (!fim_rst_n) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                shdw_tbl[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    shdw_tbl[i] <= cfg_to_entry(bus.ctl_shdw_cfg[2:0]);
                end
            end
        end
    end

    // Unpack the table into bit vectors; flag entries being disabled
    always_comb begin
        en_vec   = '0;
        mask_vec = '0;
        bme_vec  = '0;
        dis_clr  = '0;
        for (int i = 0; i < NUM_ENT; i++) begin
            en_vec[i]   = shdw_tbl[i].en;
            mask_vec[i] = shdw_tbl[i].mask;
            bme_vec[i]  = shdw_tbl[i].bme;
            dis_clr[i]  = wr_en && (wr_idx == IDX_W'(i)) && !bus.ctl_shdw_cfg[2];
        end
    end

`ifdef MSIX_SHDW_BME_GATE_EN
    assign elig = pending & en_vec & ~mask_vec & bme_vec & {NUM_ENT{grant_en}};
`else
    logic unused_bme;
    assign unused_bme = ^bme_vec;
    assign elig = pending & en_vec & ~mask_vec & {NUM_ENT{grant_en}};
`endif

    // A function being handed off this cycle must not be re-granted at once
    assign hs      = valid && bus.irq_ready;
    assign hs_clr  = hs ? grant_oh : '0;
    assign arb_req = elig & ~hs_clr;
    assign load    = (!valid || hs) && (|arb_req);

    msix_rr_arb #(
        .N (NUM_ENT)
    ) u_rr_arb (
        .clk     (fim_clk),
        .rst_n   (fim_rst_n),
        .req     (arb_req),
        .advance (load),
        .gnt     (arb_gnt)
    );

    // One-hot grant to entry index
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_ENT; i++) begin
            if (arb_gnt[i]) gnt_idx = IDX_W'(i);
        end
    end

    // Pending bits: new request wins over handshake or disable clear
    always_ff @(posedge fim_clk or negedge fim_rst_n) begin
        if (!fim_rst_n) begin
            pending <= '0;
        end else begin
            pending <= bus.irq_req | (pending & ~hs_clr & ~dis_clr);
        end
    end

    // Grant register: held until accepted, reloaded back-to-back on handshake
    always_ff @(posedge fim_clk or negedge fim_rst_n) begin
        if (!fim_rst_n) begin
            valid     <= 1'b0;
            vf_active <= 1'b0;
            vf_num    <= '0;
            grant_oh  <= '0;
        end else if (load) begin
            valid     <= 1'b1;
            vf_active <= (gnt_idx != '0);
            vf_num    <= (gnt_idx == '0) ? '0 :
                         MSIX_VF_NUM_W'(gnt_idx) - MSIX_VF_NUM_W'(1);
            grant_oh  <= arb_gnt;
        end else if (hs) begin
            valid     <= 1'b0;
        end
    end

    assign bus.ctl_shdw_req_all = req_all;
    assign bus.irq_valid        = valid;
    assign bus.irq_vf_active    = vf_active;
    assign bus.irq_vf_num       = vf_num;
    assign bus.irq_pending      = pending;

endmodule
`default_nettype wire

// File: doc/pcie_msix_irq_sched.md
PCIE_MSIX_IRQ_SCHED -- requirements
Module: pcie_msix_irq_sched

Interface
REQ-001 Parameter NUM_VF, default 4, number of VFs on PF0; function index 0 = PF0, 1..NUM_VF = VF0..VF(NUM_VF-1).
REQ-002 Parameter TIMEOUT_CYC, default 1024, cycles to wait in SHDW_INIT before re-issuing req_all.
REQ-003 fim_clk  in  1  sole clock.
REQ-004 fim_rst_n  in  1  asynchronous, active-low reset.
REQ-005 ctl_shdw_update  in  1  shadow record valid strobe from PCIe EP.
REQ-006 ctl_shdw_pf_num  in  2  PF of the shadow record.
REQ-007 ctl_shdw_vf_num  in  11  VF of the shadow record.
REQ-008 ctl_shdw_vf_active  in  1  record targets a VF.
REQ-009 ctl_shdw_cfg  in  7  [2] MSI-X enable, [1] function mask, [0] bus master enable.
REQ-010 ctl_shdw_req_all  out  1  request full shadow dump from EP.
REQ-011 shdw_rescan  in  1  single-cycle pulse forcing a new full dump.
REQ-012 irq_req  in  NUM_VF+1  per-function interrupt request pulses.
REQ-013 irq_valid / irq_ready  out / in  1 / 1  grant handshake to MSI-X table engine.
REQ-014 irq_vf_active / irq_vf_num  out / out  1 / 11  granted function identity.
REQ-015 irq_pending  out  NUM_VF+1  pending-bit vector for PBA readback.

Function
REQ-016 Shadow table SHALL hold {en, mask, bme} per function, written on ctl_shdw_update when pf_num==0 and either vf_active==0 (entry 0) or vf_num<NUM_VF (entry vf_num+1); all other records ignored.
REQ-017 Init FSM states SHDW_INIT, SHDW_RUN; SHDW_INIT drives ctl_shdw_req_all=1; first ctl_shdw_update moves to SHDW_RUN (req_all=0 next cycle).
REQ-018 SHDW_INIT with no update for TIMEOUT_CYC cycles SHALL drop req_all for one cycle, then reassert and restart the counter.
REQ-019 shdw_rescan in SHDW_RUN SHALL return FSM to SHDW_INIT; ignored in SHDW_INIT.
REQ-020 irq_req[i] SHALL set irq_pending[i] the next cycle; repeated requests coalesce into one pending bit.
REQ-021 Writing en=0 to entry i SHALL clear irq_pending[i]; mask=1 SHALL hold pending without granting.
REQ-022 Eligible[i] = pending & en & ~mask (& bme per REQ-031); no grants while FSM in SHDW_INIT.
REQ-023 Round-robin selection starting at index after last grant; granted entry registered into irq_vf_*, irq_valid=1 one cycle after eligibility (irq_req to irq_valid minimum 2 cycles).
REQ-024 irq_valid and identity SHALL stay stable until irq_ready; later mask/disable changes do not retract an issued grant.
REQ-025 On handshake, pending of granted function cleared; simultaneous irq_req for same function wins (bit stays set).
REQ-026 Back-to-back grants allowed: irq_valid may stay high on the cycle after a handshake for the next eligible function.
REQ-027 Entry 0 reports irq_vf_active=0, irq_vf_num=0; entry k>0 reports vf_active=1, vf_num=k-1.

Reset
REQ-028 On fim_rst_n=0: FSM=SHDW_INIT, ctl_shdw_req_all=1, table all zero, irq_pending=0, irq_valid=0, irq_vf_*=0, RR pointer=0, timeout counter=0.
REQ-029 Reset asserted mid-handshake SHALL drop irq_valid immediately; the grant is lost, not replayed.

Configuration
REQ-030 Macro MSIX_SHDW_BME_GATE_EN selects bus-master gating.
REQ-031 Defined: eligibility additionally requires bme=1; undefined: bme stored but ignored.

Structure
REQ-032 ofs_fim_pcie_pkg SHALL hold typedef t_msix_shdw_entry {en, mask, bme} and localparam MSIX_VF_NUM_W=11.
REQ-033 Round-robin logic SHALL be sub-module msix_rr_arb (request vector, advance strobe, one-hot grant).

Verification
REQ-034 Reset release, no update for 1024 cycles -> req_all low 1 cycle, high again; then update pf0 cfg=7'h04 -> SHDW_RUN, req_all=0.
REQ-035 VF2 en=1, mask=0; irq_req[3] pulse -> irq_valid 2 cycles later, vf_active=1, vf_num=2; irq_ready=1 -> pending[3]=0.
REQ-036 Pending on entries 1,2,4 with irq_ready=1 -> grants in order 1,2,4, back-to-back, then 1 again when re-requested.
REQ-037 VF0 mask=1 with irq_req -> no grant, pending stays 1; mask=0 update -> grant; en=0 update instead -> pending cleared, no grant.
REQ-038 Record with vf_num=9 (NUM_VF=4) or pf_num=1 -> table unchanged.
REQ-039 cfg=7'h04 (bme=0): with MSIX_SHDW_BME_GATE_EN no grant, without it grant issued.
